// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg -- shared VGA timing constants and types.
//
// Holds the 640x480@60 timing numbers, the pixel coordinate width, the bundle
// of per-pixel control flags that travels down the sync delay line, and a
// small range-decode helper used for the sync pulse windows.
// -----------------------------------------------------------------------------
package vga_pkg;

  // Pixel coordinate width; wide enough for an 800-count line.
  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  // Horizontal timing in pixel clocks.
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing in lines.
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Control flags that must stay aligned with the colour pipeline.
  // Syncs are carried active-low, exactly as they leave the chip.
  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } sync_flags_t;

  // Value of a flag bundle during reset and blanking: no picture, no sync.
  localparam sync_flags_t SYNC_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  // True when lo <= v < hi.
  function automatic logic in_range(input coord_t v, input int lo, input int hi);
    return (v >= coord_t'(lo)) && (v < coord_t'(hi));
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// -----------------------------------------------------------------------------
// sync_delay_line -- enable-qualified shift register for {active, hs, vs}.
//
// Delays the decoded timing flags by DEPTH enabled cycles so they line up with
// the colour returned by the object mux for the same pixel.
//
// Ports
//   clk      in   system clock, rising edge
//   resetN   in   asynchronous active-low reset; clears every stage to idle
//   en_i     in   pixel enable; the line shifts only when high
//   flags_i  in   undelayed flags decoded from the counters
//   flags_o  out  flags delayed by DEPTH enabled cycles
// -----------------------------------------------------------------------------
module sync_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        en_i,
  input  sync_flags_t flags_i,
  output sync_flags_t flags_o
);

  sync_flags_t stage_q [DEPTH];

  // NOTE: every stage of this storage array is reset, not just the head; a
  // stale sync bit left in the line would leave as a spurious pulse after reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= SYNC_IDLE;
    end else if (en_i) begin
      stage_q[0] <= flags_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign flags_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_display_driver.sv
// -----------------------------------------------------------------------------
// vga_display_driver -- VGA raster timing generator and output stage.
//
// Counts pixels and lines, hands the current coordinate to the drawing objects,
// delays the blanking/sync decode by LATENCY enabled cycles to meet the colour
// coming back from the object mux, then registers colour, blank and syncs for
// the DAC. Outputs therefore trail their coordinate by LATENCY+1 enabled cycles.
// Timing defaults to the shared 640x480@60 constants; the overrides exist so
// the same logic can be run on a shortened raster.
//
// Ports
//   clk           in   system clock, rising edge
//   resetN        in   asynchronous active-low reset
//   pxlEn         in   pixel-rate enable; nothing advances while low
//   redIn/greenIn/blueIn  in  8-bit colour from the object mux
//   pixelX/pixelY out  current horizontal / vertical count
//   startOfFrame  out  high on the last pixel of a frame, before pixel (0,0)
//   vgaR/vgaG/vgaB out 8-bit colour to the DAC, zero while blanked
//   vgaHS/vgaVS   out  active-low horizontal / vertical sync
//   vgaBlankN     out  high during visible pixels
// -----------------------------------------------------------------------------
module vga_display_driver
  import vga_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FRONT  = H_FRONT,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BACK   = H_BACK,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FRONT  = V_FRONT,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BACK   = V_BACK
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               pxlEn,
  input  logic [7:0]         redIn,
  input  logic [7:0]         greenIn,
  input  logic [7:0]         blueIn,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               startOfFrame,
  output logic [7:0]         vgaR,
  output logic [7:0]         vgaG,
  output logic [7:0]         vgaB,
  output logic               vgaHS,
  output logic               vgaVS,
  output logic               vgaBlankN
);

  localparam int HS_START = P_H_ACTIVE + P_H_FRONT;
  localparam int HS_END   = HS_START + P_H_SYNC;
  localparam int HTOTAL   = HS_END + P_H_BACK;
  localparam int VS_START = P_V_ACTIVE + P_V_FRONT;
  localparam int VS_END   = VS_START + P_V_SYNC;
  localparam int VTOTAL   = VS_END + P_V_BACK;

  if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
    $error("vga_display_driver: LATENCY must be in 1..4");
  end

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  logic   h_last, v_last;

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default before any branch, so no path leaves a value held (no latch).
  always_comb begin
    h_last  = (h_cnt_q == coord_t'(HTOTAL - 1));
    v_last  = (v_cnt_q == coord_t'(VTOTAL - 1));
    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    // The line counter moves only on the line wrap; on the last line this is
    // a single joint step back to (0,0).
    if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
  end

  // NOTE: clocked blocks use non-blocking '<=' so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (pxlEn) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign pixelX = h_cnt_q;
  assign pixelY = v_cnt_q;

  // Undelayed: objects see it on the last pixel and latch per-frame state
  // before (0,0). It follows the counters, so it stays high while pxlEn is
  // low at that position and is low in reset.
  assign startOfFrame = h_last && v_last;

  // ---------------------------------------------------------------------------
  // Timing decode and alignment with the object-mux latency
  // ---------------------------------------------------------------------------
  sync_flags_t raw_flags, dly_flags;

  always_comb begin
    raw_flags        = SYNC_IDLE;
    raw_flags.active = (h_cnt_q < coord_t'(P_H_ACTIVE)) && (v_cnt_q < coord_t'(P_V_ACTIVE));
    raw_flags.hs_n   = !in_range(h_cnt_q, HS_START, HS_END);
    raw_flags.vs_n   = !in_range(v_cnt_q, VS_START, VS_END);
  end

  sync_delay_line #(
    .DEPTH (LATENCY)
  ) u_sync_delay_line (
    .clk     (clk),
    .resetN  (resetN),
    .en_i    (pxlEn),
    .flags_i (raw_flags),
    .flags_o (dly_flags)
  );

  // ---------------------------------------------------------------------------
  // Output register: colour is forced to black outside the visible area,
  // whatever the object mux is driving.
  // ---------------------------------------------------------------------------
  logic [7:0] vga_r_q, vga_r_d;
  logic [7:0] vga_g_q, vga_g_d;
  logic [7:0] vga_b_q, vga_b_d;
  logic       hs_n_q, vs_n_q, blank_n_q;

  always_comb begin
    vga_r_d = '0;
    vga_g_d = '0;
    vga_b_d = '0;
    if (dly_flags.active) begin
      vga_r_d = redIn;
      vga_g_d = greenIn;
      vga_b_d = blueIn;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vga_r_q   <= '0;
      vga_g_q   <= '0;
      vga_b_q   <= '0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
    end else if (pxlEn) begin
      vga_r_q   <= vga_r_d;
      vga_g_q   <= vga_g_d;
      vga_b_q   <= vga_b_d;
      hs_n_q    <= dly_flags.hs_n;
      vs_n_q    <= dly_flags.vs_n;
      blank_n_q <= dly_flags.active;
    end
  end

  assign vgaR      = vga_r_q;
  assign vgaG      = vga_g_q;
  assign vgaB      = vga_b_q;
  assign vgaHS     = hs_n_q;
  assign vgaVS     = vs_n_q;
  assign vgaBlankN = blank_n_q;

endmodule

// File: tb/tb_vga_display_driver.sv
// -----------------------------------------------------------------------------
// tb_vga_display_driver -- directed self-checking bench.
//
// u_full  : real 640x480 timing, LATENCY=1, used for line-level behaviour.
// u_small : shortened raster (16x9 total, 8x4 visible), LATENCY=1, used for
//           frame-level behaviour: vsync, startOfFrame, wrap, enable gating,
//           mid-frame reset.
// u_lat3  : same shortened raster, LATENCY=3, fed by a 3-cycle colour model.
// Every sample is taken 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_vga_display_driver;

  // Shortened raster used by u_small and u_lat3.
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_HT = 16, S_VT = 9, S_FRAME = 144;
  localparam int S_HSS = 10, S_HSE = 13, S_VSS = 5, S_VSE = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u_full signals
  logic        f_rst_n, f_en;
  logic [7:0]  f_r, f_g, f_b, f_vr, f_vg, f_vb;
  logic [10:0] f_x, f_y;
  logic        f_sof, f_hs, f_vs, f_bl;
  // u_small signals
  logic        s_rst_n, s_en;
  logic [7:0]  s_r, s_g, s_b, s_vr, s_vg, s_vb;
  logic [10:0] s_x, s_y;
  logic        s_sof, s_hs, s_vs, s_bl;
  // u_lat3 signals
  logic        l_rst_n, l_en;
  logic [7:0]  l_r, l_g, l_b, l_vr, l_vg, l_vb;
  logic [10:0] l_x, l_y;
  logic        l_sof, l_hs, l_vs, l_bl;

  vga_display_driver #(.LATENCY(1)) u_full (
    .clk(clk), .resetN(f_rst_n), .pxlEn(f_en),
    .redIn(f_r), .greenIn(f_g), .blueIn(f_b),
    .pixelX(f_x), .pixelY(f_y), .startOfFrame(f_sof),
    .vgaR(f_vr), .vgaG(f_vg), .vgaB(f_vb),
    .vgaHS(f_hs), .vgaVS(f_vs), .vgaBlankN(f_bl)
  );

  vga_display_driver #(
    .LATENCY(1),
    .P_H_ACTIVE(S_HA), .P_H_FRONT(S_HF), .P_H_SYNC(S_HS), .P_H_BACK(S_HB),
    .P_V_ACTIVE(S_VA), .P_V_FRONT(S_VF), .P_V_SYNC(S_VS), .P_V_BACK(S_VB)
  ) u_small (
    .clk(clk), .resetN(s_rst_n), .pxlEn(s_en),
    .redIn(s_r), .greenIn(s_g), .blueIn(s_b),
    .pixelX(s_x), .pixelY(s_y), .startOfFrame(s_sof),
    .vgaR(s_vr), .vgaG(s_vg), .vgaB(s_vb),
    .vgaHS(s_hs), .vgaVS(s_vs), .vgaBlankN(s_bl)
  );

  vga_display_driver #(
    .LATENCY(3),
    .P_H_ACTIVE(S_HA), .P_H_FRONT(S_HF), .P_H_SYNC(S_HS), .P_H_BACK(S_HB),
    .P_V_ACTIVE(S_VA), .P_V_FRONT(S_VF), .P_V_SYNC(S_VS), .P_V_BACK(S_VB)
  ) u_lat3 (
    .clk(clk), .resetN(l_rst_n), .pxlEn(l_en),
    .redIn(l_r), .greenIn(l_g), .blueIn(l_b),
    .pixelX(l_x), .pixelY(l_y), .startOfFrame(l_sof),
    .vgaR(l_vr), .vgaG(l_vg), .vgaB(l_vb),
    .vgaHS(l_hs), .vgaVS(l_vs), .vgaBlankN(l_bl)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {x, y, sof, vgaR, hs, vs, blankN} of u_small after n enabled
  // edges from reset release, with redIn held at 8'hFF.
  function automatic logic [33:0] exp_small(input int n);
    int c, x, y, cd, xd, yd;
    logic [7:0] r;
    logic hs, vs, bl, sof;
    c   = n % S_FRAME;
    x   = c % S_HT;
    y   = c / S_HT;
    sof = (x == S_HT - 1) && (y == S_VT - 1);
    r = 8'h00; hs = 1'b1; vs = 1'b1; bl = 1'b0;
    if (n >= 2) begin
      cd = (n - 2) % S_FRAME;
      xd = cd % S_HT;
      yd = cd / S_HT;
      bl = (xd < S_HA) && (yd < S_VA);
      r  = bl ? 8'hFF : 8'h00;
      hs = !((xd >= S_HSS) && (xd < S_HSE));
      vs = !((yd >= S_VSS) && (yd < S_VSE));
    end
    return {x[10:0], y[10:0], sof, r, hs, vs, bl};
  endfunction

  // Colour the model object mux assigns to raster position c.
  function automatic logic [7:0] model_red(input int c);
    int v;
    v = (c % S_HT) * 16 + (c / S_HT) + 1;
    return v[7:0];
  endfunction

  function automatic logic [33:0] obs_small();
    return {s_x, s_y, s_sof, s_vr, s_hs, s_vs, s_bl};
  endfunction

  initial begin
    int mm, hs_low, vs_low, ff_cnt, first_ff, sof_cnt, vis_cnt;
    int xd, cd, rise1, rise2, m;
    logic vis, prev_sof;
    logic [7:0] er, eg, eb;
    logic ehs, evs;

    f_rst_n = 1'b0; s_rst_n = 1'b0; l_rst_n = 1'b0;
    f_en = 1'b0; s_en = 1'b0; l_en = 1'b0;
    f_r = 8'hFF; f_g = 8'h12; f_b = 8'h34;
    s_r = 8'hFF; s_g = 8'h33; s_b = 8'hCC;
    l_r = 8'hEE; l_g = 8'hEE; l_b = 8'hEE;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_pixelX", f_x, 0);
    check("rst_pixelY", f_y, 0);
    check("rst_sof", f_sof, 0);
    check("rst_vgaR", f_vr, 0);
    check("rst_vgaG", f_vg, 0);
    check("rst_vgaB", f_vb, 0);
    check("rst_vgaHS", f_hs, 1);
    check("rst_vgaVS", f_vs, 1);
    check("rst_blankN", f_bl, 0);
    check("rst_lat3_blankN", l_bl, 0);

    // ---------------- full raster, two lines, pxlEn=1 ----------------
    f_rst_n = 1'b1; f_en = 1'b1;
    mm = 0; hs_low = 0; ff_cnt = 0; first_ff = -1;
    for (int n = 0; n <= 1602; n++) begin
      if (n != 0) tick();
      if (int'(f_x) != n % 800 || int'(f_y) != n / 800 || f_sof !== 1'b0) mm++;
      if (n >= 2) begin
        xd  = (n - 2) % 800;
        vis = (xd < 640);
        if (f_vr !== (vis ? 8'hFF : 8'h00) || f_vg !== (vis ? 8'h12 : 8'h00) ||
            f_vb !== (vis ? 8'h34 : 8'h00) || f_bl !== vis ||
            f_hs !== !((xd >= 656) && (xd < 752)) || f_vs !== 1'b1) mm++;
        if (n < 802) begin
          if (f_hs == 1'b0) hs_low++;
          if (f_vr == 8'hFF) ff_cnt++;
        end
      end
      if (first_ff < 0 && f_vr == 8'hFF) first_ff = n;
      if (n == 1) check("full_r_before_pixel0", f_vr, 0);
      if (n == 800) begin
        check("full_line_wrap_x", f_x, 0);
        check("full_line_wrap_y", f_y, 1);
      end
    end
    f_en = 1'b0;
    check("full_trace_mismatches", mm, 0);
    check("full_hs_low_per_line", hs_low, 96);
    check("full_first_ff_latency", first_ff, 2);
    check("full_visible_run", ff_cnt, 640);

    // ---------------- small raster, two frames, pxlEn=1 ----------------
    s_rst_n = 1'b1; s_en = 1'b1;
    mm = 0; vs_low = 0; sof_cnt = 0; prev_sof = 1'b0;
    for (int n = 0; n <= 2 * S_FRAME; n++) begin
      if (n != 0) tick();
      if (obs_small() !== exp_small(n)) mm++;
      if (n >= 2 && n < 2 + S_FRAME && s_vs == 1'b0) vs_low++;
      if (n < S_FRAME && s_sof == 1'b1) sof_cnt++;
      if (prev_sof) begin
        check("sof_next_x", s_x, 0);
        check("sof_next_y", s_y, 0);
      end
      prev_sof = s_sof;
    end
    check("small_trace_mismatches", mm, 0);
    check("small_vs_low_per_frame", vs_low, 32);
    check("small_sof_per_frame", sof_cnt, 1);

    // ---------------- small raster, pxlEn toggling 1,0,1,0 ----------------
    s_rst_n = 1'b0;
    tick(); tick();
    s_rst_n = 1'b1;
    mm = 0; m = 0; rise1 = -1; rise2 = -1; prev_sof = 1'b0;
    if (obs_small() !== exp_small(0)) mm++;
    for (int k = 1; k <= 600; k++) begin
      s_en = k[0];
      tick();
      if (k[0]) m++;
      if (obs_small() !== exp_small(m)) mm++;
      if (s_sof && !prev_sof) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      prev_sof = s_sof;
      if (k == 286) check("sof_held_while_disabled", s_sof, 1);
    end
    check("toggle_trace_mismatches", mm, 0);
    check("toggle_frame_len", rise2 - rise1, 2 * S_FRAME);

    // ---------------- small raster, reset mid-frame at (5,2) ----------------
    s_rst_n = 1'b0;
    tick();
    s_rst_n = 1'b1; s_en = 1'b1;
    for (int n = 0; n <= 37; n++) begin
      if (n != 0) tick();
    end
    check("pre_reset_x", s_x, 5);
    check("pre_reset_y", s_y, 2);
    check("pre_reset_r", s_vr, 8'hFF);
    check("pre_reset_blankN", s_bl, 1);
    s_rst_n = 1'b0;
    #1;
    check("async_rst_x", s_x, 0);
    check("async_rst_y", s_y, 0);
    check("async_rst_r", s_vr, 0);
    check("async_rst_blankN", s_bl, 0);
    check("async_rst_hs_vs", {s_hs, s_vs}, 2'b11);
    tick(); tick();
    s_rst_n = 1'b1;
    mm = 0;
    for (int n = 0; n <= S_FRAME + 6; n++) begin
      if (n != 0) tick();
      if (obs_small() !== exp_small(n)) mm++;
    end
    check("post_reset_mismatches", mm, 0);
    s_en = 1'b0;

    // ---------------- LATENCY=3 with 3-cycle colour model ----------------
    l_rst_n = 1'b1; l_en = 1'b1;
    mm = 0; vis_cnt = 0;
    for (int n = 0; n <= 2 * S_FRAME + 2; n++) begin
      if (n != 0) tick();
      er = 8'h00; eg = 8'h00; eb = 8'h00; ehs = 1'b1; evs = 1'b1; vis = 1'b0;
      if (n >= 4) begin
        cd  = (n - 4) % S_FRAME;
        vis = ((cd % S_HT) < S_HA) && ((cd / S_HT) < S_VA);
        ehs = !(((cd % S_HT) >= S_HSS) && ((cd % S_HT) < S_HSE));
        evs = !(((cd / S_HT) >= S_VSS) && ((cd / S_HT) < S_VSE));
        if (vis) begin
          er = model_red(cd);
          eg = ~model_red(cd);
          eb = model_red(cd) ^ 8'h5A;
        end
      end
      if (l_vr !== er || l_vg !== eg || l_vb !== eb ||
          l_bl !== vis || l_hs !== ehs || l_vs !== evs) mm++;
      if (n >= 4 && n < 4 + S_FRAME && l_bl == 1'b1) vis_cnt++;
      if (n == 3) check("lat3_before_pixel0", l_vr, 0);
      if (n == 4) check("lat3_pixel0_colour", l_vr, 8'h01);
      // Object-mux model: colour of the pixel presented three enabled cycles ago.
      if (n >= 3) begin
        cd  = (n - 3) % S_FRAME;
        l_r = model_red(cd);
        l_g = ~model_red(cd);
        l_b = model_red(cd) ^ 8'h5A;
      end else begin
        l_r = 8'hEE; l_g = 8'hEE; l_b = 8'hEE;
      end
    end
    check("lat3_colour_mismatches", mm, 0);
    check("lat3_visible_per_frame", vis_cnt, S_HA * S_VA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
